// File: rtl/searcher_sequencer.sv
// searcher_sequencer
//   Front-end controller for the two-phase closest-value searcher. It loads a
//   sorted note table into the searcher and then serves pitch snap requests
//   one at a time. A search that never finds an answer is cut off by a
//   timeout, which returns the largest table value and resets the searcher.
//
// Ports
//   clk_in, rst_in           clock, synchronous active-low reset
//   load_start_in            start a new table load (accepted in IDLE only)
//   tbl_val/valid/last_in    table entry stream; tbl_ready_out accepts
//   req_val/valid_in         snap request; req_ready_out accepts
//   res_val/timeout/valid    result, held until res_ready_in
//   busy_out                 controller not idle
//   tbl_len_out              number of entries in the current table
//   sort_err_out             sticky: non-ascending entry or overflow
//   srch_*_out / srch_*_in   searcher reset, store, search and result pins
//
// state    | meaning
// S_SRST   | searcher reset for 2 cycles, then IDLE or LOAD
// S_IDLE   | wait for load start or request
// S_LOAD   | accept entries, hold each on the store pins for 2 cycles
// S_SEARCH | searching asserted, waiting for found or timeout
// S_DRAIN  | searching dropped, waiting for found to clear
// S_TORST  | timeout: searcher reset for 2 cycles
// S_RESULT | result valid until consumed
module searcher_sequencer #(
  parameter int WIDTH         = 12,
  parameter int BRAM_SIZE     = 256,
  parameter int TIMEOUT_SLACK = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         load_start_in,
  input  logic [WIDTH-1:0]             tbl_val_in,
  input  logic                         tbl_valid_in,
  input  logic                         tbl_last_in,
  output logic                         tbl_ready_out,
  input  logic [WIDTH-1:0]             req_val_in,
  input  logic                         req_valid_in,
  output logic                         req_ready_out,
  output logic [WIDTH-1:0]             res_val_out,
  output logic                         res_timeout_out,
  output logic                         res_valid_out,
  input  logic                         res_ready_in,
  output logic                         busy_out,
  output logic [$clog2(BRAM_SIZE):0]   tbl_len_out,
  output logic                         sort_err_out,
  output logic                         srch_rst_out,
  output logic                         srch_store_valid_out,
  output logic [WIDTH-1:0]             srch_store_val_out,
  output logic                         srch_searching_out,
  output logic [WIDTH-1:0]             srch_search_val_out,
  input  logic [WIDTH-1:0]             srch_closest_in,
  input  logic                         srch_found_in
);

  localparam int LW = $clog2(BRAM_SIZE) + 1;
  localparam int CW = $clog2(2 * BRAM_SIZE + TIMEOUT_SLACK + 1) + 1;

  typedef enum logic [2:0] {
    S_SRST, S_IDLE, S_LOAD, S_SEARCH, S_DRAIN, S_TORST, S_RESULT
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     timeout_lim;
  logic [LW-1:0]     tbl_len;
  logic [WIDTH-1:0]  max_val, req_val, res_val, store_val;
  logic [1:0]        hold_cnt;
  logic              last_r, load_pend, res_timeout, sort_err;
  logic              tbl_full, tbl_acc, req_acc;
  logic              tbl_ready, req_ready, searching, srch_rst, res_valid;

  assign tbl_full    = (tbl_len == LW'(BRAM_SIZE));
  assign timeout_lim = CW'({tbl_len, 1'b0}) + CW'(TIMEOUT_SLACK);
  assign tbl_acc     = tbl_ready & tbl_valid_in;
  assign req_acc     = req_ready & req_valid_in;

  always_comb begin
    state_next = state;
    tbl_ready  = 1'b0;
    req_ready  = 1'b0;
    searching  = 1'b0;
    srch_rst   = 1'b0;
    res_valid  = 1'b0;
    case (state)
      S_SRST: begin
        srch_rst = 1'b1;
        if (cnt == CW'(1)) state_next = load_pend ? S_LOAD : S_IDLE;
      end
      S_IDLE: begin
        if (load_start_in) begin
          state_next = S_SRST;
        end else begin
          req_ready = 1'b1;
          if (req_valid_in) state_next = (tbl_len == '0) ? S_RESULT : S_SEARCH;
        end
      end
      S_LOAD: begin
        // one entry in flight at a time so every entry gets a full even phase
        tbl_ready = (hold_cnt == 2'd0) && !tbl_full;
        if (hold_cnt == 2'd1 && (last_r || tbl_full)) state_next = S_IDLE;
        else if (hold_cnt == 2'd0 && tbl_full)        state_next = S_IDLE;
      end
      S_SEARCH: begin
        searching = 1'b1;
        if (srch_found_in)            state_next = S_DRAIN;
        else if (cnt == timeout_lim)  state_next = S_TORST;
      end
      S_DRAIN: begin
        if (!srch_found_in) state_next = S_RESULT;
      end
      S_TORST: begin
        srch_rst = 1'b1;
        if (cnt == CW'(1)) state_next = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready_in) state_next = S_IDLE;
      end
      default: state_next = S_SRST;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= S_SRST;
      cnt         <= '0;
      tbl_len     <= '0;
      max_val     <= '0;
      sort_err    <= 1'b0;
      req_val     <= '0;
      res_val     <= '0;
      res_timeout <= 1'b0;
      store_val   <= '0;
      hold_cnt    <= 2'd0;
      last_r      <= 1'b0;
      load_pend   <= 1'b0;
    end else begin
      state <= state_next;
      // cnt measures time spent in the current state
      if (state_next != state)  cnt <= '0;
      else if (cnt != '1)       cnt <= cnt + CW'(1);

      if (state == S_IDLE && load_start_in) begin
        tbl_len   <= '0;
        max_val   <= '0;
        sort_err  <= 1'b0;
        load_pend <= 1'b1;
      end
      if (state == S_SRST && cnt == CW'(1)) load_pend <= 1'b0;

      if (req_acc) begin
        req_val <= req_val_in;
        if (tbl_len == '0) begin
          res_val     <= '0;
          res_timeout <= 1'b1;
        end
      end

      if (tbl_acc) begin
        store_val <= tbl_val_in;
        hold_cnt  <= 2'd2;
        last_r    <= tbl_last_in;
        tbl_len   <= tbl_len + LW'(1);
        max_val   <= tbl_val_in;
        if (tbl_len != '0 && tbl_val_in <= max_val) sort_err <= 1'b1;
      end else if (hold_cnt != 2'd0) begin
        hold_cnt <= hold_cnt - 2'd1;
        if (hold_cnt == 2'd1 && tbl_full && !last_r) sort_err <= 1'b1;
      end

      if (state == S_SEARCH) begin
        if (srch_found_in) begin
          res_val     <= srch_closest_in;
          res_timeout <= 1'b0;
        end else if (cnt == timeout_lim) begin
          res_val     <= max_val;
          res_timeout <= 1'b1;
        end
      end
    end
  end

  assign tbl_ready_out        = tbl_ready;
  assign req_ready_out        = req_ready;
  assign res_valid_out        = res_valid;
  assign res_val_out          = res_val;
  assign res_timeout_out      = res_timeout;
  assign busy_out             = (state != S_IDLE);
  assign tbl_len_out          = tbl_len;
  assign sort_err_out         = sort_err;
  assign srch_rst_out         = srch_rst;
  assign srch_store_valid_out = (hold_cnt != 2'd0);
  assign srch_store_val_out   = store_val;
  assign srch_searching_out   = searching;
  assign srch_search_val_out  = searching ? req_val : '0;

endmodule

// File: tb/tb_searcher_sequencer.sv
module tb_searcher_sequencer;
  localparam int WIDTH = 12;
  localparam int BRAM_SIZE = 256;
  localparam int SLACK = 8;

  typedef logic [WIDTH-1:0] val_q_t[$];

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              load_start_in;
  logic [WIDTH-1:0]  tbl_val_in;
  logic              tbl_valid_in, tbl_last_in, tbl_ready_out;
  logic [WIDTH-1:0]  req_val_in;
  logic              req_valid_in, req_ready_out;
  logic [WIDTH-1:0]  res_val_out;
  logic              res_timeout_out, res_valid_out, res_ready_in, busy_out;
  logic [8:0]        tbl_len_out;
  logic              sort_err_out, srch_rst_out, srch_store_valid_out;
  logic [WIDTH-1:0]  srch_store_val_out;
  logic              srch_searching_out;
  logic [WIDTH-1:0]  srch_search_val_out;
  logic [WIDTH-1:0]  srch_closest_in;
  logic              srch_found_in;

  searcher_sequencer #(.WIDTH(WIDTH), .BRAM_SIZE(BRAM_SIZE), .TIMEOUT_SLACK(SLACK)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .load_start_in(load_start_in),
    .tbl_val_in(tbl_val_in), .tbl_valid_in(tbl_valid_in), .tbl_last_in(tbl_last_in),
    .tbl_ready_out(tbl_ready_out), .req_val_in(req_val_in), .req_valid_in(req_valid_in),
    .req_ready_out(req_ready_out), .res_val_out(res_val_out), .res_timeout_out(res_timeout_out),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .busy_out(busy_out),
    .tbl_len_out(tbl_len_out), .sort_err_out(sort_err_out), .srch_rst_out(srch_rst_out),
    .srch_store_valid_out(srch_store_valid_out), .srch_store_val_out(srch_store_val_out),
    .srch_searching_out(srch_searching_out), .srch_search_val_out(srch_search_val_out),
    .srch_closest_in(srch_closest_in), .srch_found_in(srch_found_in)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // nearest entry to r (ties go to the lower value); ok says whether any entry is >= r
  function automatic void near_of(input val_q_t q, input logic [WIDTH-1:0] r,
                                  output bit ok, output logic [WIDTH-1:0] v);
    int best = 1 << 30;
    int d;
    ok = 0;
    v = '0;
    foreach (q[i]) begin
      if (q[i] >= r) ok = 1;
      d = (q[i] > r) ? int'(q[i]) - int'(r) : int'(r) - int'(q[i]);
      if (d < best || (d == best && q[i] < v)) begin
        best = d;
        v = q[i];
      end
    end
  endfunction

  // searcher stand-in plus pulse monitors, all sampled at the active edge
  val_q_t sm_q;
  int     sm_cnt = 0, sm_lat = 0, sm_dr = 0;
  bit     prev_store = 0, prev_searching = 0;
  int     st_run = 0, st_pulses = 0, st_bad = 0;
  int     rs_run = 0, rs_last = 0;
  int     srch_cycles = 0, viol = 0;

  always @(posedge clk_in) begin
    bit ok;
    logic [WIDTH-1:0] v;
    if (srch_store_valid_out) st_run++;
    else if (st_run != 0) begin
      st_pulses++;
      if (st_run != 2) st_bad++;
      st_run = 0;
    end
    if (srch_rst_out) rs_run++;
    else if (rs_run != 0) begin
      rs_last = rs_run;
      rs_run = 0;
    end
    if (srch_searching_out) srch_cycles++;
    if (srch_searching_out && !prev_searching && srch_found_in) viol++;
    prev_searching = srch_searching_out;

    if (load_start_in && !busy_out) sm_q.delete();
    if (srch_store_valid_out && !prev_store) sm_q.push_back(srch_store_val_out);
    prev_store = srch_store_valid_out;

    if (!rst_in || srch_rst_out) begin
      srch_found_in <= 1'b0;
      sm_cnt = 0;
      sm_dr = 0;
    end else if (srch_searching_out) begin
      sm_dr = 0;
      if (!srch_found_in) begin
        if (sm_cnt == 0) sm_lat = $urandom_range(0, 3);
        if (sm_cnt >= sm_lat) begin
          near_of(sm_q, srch_search_val_out, ok, v);
          if (ok) begin
            srch_found_in   <= 1'b1;
            srch_closest_in <= v;
          end
        end
        sm_cnt++;
      end
    end else begin
      sm_cnt = 0;
      if (srch_found_in) begin
        if (sm_dr >= 1 || $urandom_range(0, 1) == 1) srch_found_in <= 1'b0;
        sm_dr++;
      end
    end
  end

  val_q_t ref_tbl;

  task automatic ref_expect(input logic [WIDTH-1:0] r, output logic [WIDTH-1:0] ev, output bit eto);
    bit ok;
    logic [WIDTH-1:0] v;
    if (ref_tbl.size() == 0) begin
      ev = '0;
      eto = 1;
    end else begin
      near_of(ref_tbl, r, ok, v);
      ev = ok ? v : ref_tbl[ref_tbl.size()-1];
      eto = !ok;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_out && t < 3000) begin
      @(negedge clk_in);
      t++;
    end
    if (busy_out) chk("idle_wait", 32'(busy_out), 32'd0);
  endtask

  task automatic load_table(input val_q_t vals, input bit with_last);
    int t;
    wait_idle();
    ref_tbl = {};
    load_start_in = 1'b1;
    @(negedge clk_in);
    load_start_in = 1'b0;
    foreach (vals[i]) begin
      tbl_val_in   = vals[i];
      tbl_valid_in = 1'b1;
      tbl_last_in  = with_last && (i == vals.size() - 1);
      t = 0;
      while (!tbl_ready_out && t < 100) begin
        @(negedge clk_in);
        t++;
      end
      if (!tbl_ready_out) begin
        chk("tbl_ready_wait", 32'(tbl_ready_out), 32'd1);
        break;
      end
      @(negedge clk_in);
      ref_tbl.push_back(vals[i]);
    end
    tbl_valid_in = 1'b0;
    tbl_last_in  = 1'b0;
    wait_idle();
    @(negedge clk_in);
  endtask

  task automatic issue_req(input logic [WIDTH-1:0] v, output int lat);
    int t = 0;
    while (!req_ready_out && t < 3000) begin
      @(negedge clk_in);
      t++;
    end
    req_val_in   = v;
    req_valid_in = 1'b1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    lat = 1;
    while (!res_valid_out && lat < 1000) begin
      @(negedge clk_in);
      lat++;
    end
    chk("res_valid", 32'(res_valid_out), 32'd1);
  endtask

  task automatic check_req(input logic [WIDTH-1:0] v);
    int lat;
    logic [WIDTH-1:0] ev;
    bit eto;
    issue_req(v, lat);
    ref_expect(v, ev, eto);
    chk($sformatf("res_val(req %0d)", v), 32'(res_val_out), 32'(ev));
    chk($sformatf("res_timeout(req %0d)", v), 32'(res_timeout_out), 32'(eto));
    res_ready_in = 1'b1;
    @(negedge clk_in);
    res_ready_in = 1'b0;
    if (eto && ref_tbl.size() != 0) begin
      chk("timeout_latency_ok", 32'(lat <= 2 * ref_tbl.size() + SLACK + 4), 32'd1);
      chk("timeout_srch_rst_len", 32'(rs_last), 32'd2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_srch_rst"}, 32'(srch_rst_out), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid_out), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready_out), 32'd0);
    chk({tag, "_tbl_ready"}, 32'(tbl_ready_out), 32'd0);
    chk({tag, "_searching"}, 32'(srch_searching_out), 32'd0);
    chk({tag, "_store_valid"}, 32'(srch_store_valid_out), 32'd0);
    chk({tag, "_tbl_len"}, 32'(tbl_len_out), 32'd0);
    chk({tag, "_sort_err"}, 32'(sort_err_out), 32'd0);
  endtask

  initial begin
    val_q_t tq;
    int s0, lat, n, t, len;
    logic [WIDTH-1:0] pv;

    rst_in = 1'b0;
    load_start_in = 1'b0;
    tbl_val_in = '0;
    tbl_valid_in = 1'b0;
    tbl_last_in = 1'b0;
    req_val_in = '0;
    req_valid_in = 1'b0;
    res_ready_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset");
    chk("reset_res_val", 32'(res_val_out), 32'd0);
    rst_in = 1'b1;
    wait_idle();

    // request with no table: fallback immediately, searcher untouched
    s0 = srch_cycles;
    issue_req(12'd240, lat);
    chk("empty_res_val", 32'(res_val_out), 32'd0);
    chk("empty_timeout", 32'(res_timeout_out), 32'd1);
    chk("empty_latency_ok", 32'(lat <= 2), 32'd1);
    res_ready_in = 1'b1;
    @(negedge clk_in);
    res_ready_in = 1'b0;
    chk("empty_no_searching", 32'(srch_cycles - s0), 32'd0);

    // directed table
    s0 = st_pulses;
    load_table('{12'd100, 12'd200, 12'd300, 12'd400}, 1);
    chk("load4_len", 32'(tbl_len_out), 32'd4);
    chk("load4_sort_err", 32'(sort_err_out), 32'd0);
    chk("load4_store_pulses", 32'(st_pulses - s0), 32'd4);
    chk("store_pulse_width_bad", 32'(st_bad), 32'd0);
    check_req(12'd240);
    check_req(12'd260);
    check_req(12'd50);
    check_req(12'd300);
    check_req(12'd450);
    check_req(12'd240);

    // random ascending tables and random requests
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 12);
      tq = {};
      pv = 12'($urandom_range(0, 100));
      for (int i = 0; i < len; i++) begin
        tq.push_back(pv);
        pv = pv + 12'($urandom_range(1, 300));
      end
      load_table(tq, 1);
      chk("rand_len", 32'(tbl_len_out), 32'(len));
      chk("rand_sort_err", 32'(sort_err_out), 32'd0);
      for (int k = 0; k < 6; k++) check_req(12'($urandom_range(0, 4095)));
    end
    chk("store_pulse_width_bad", 32'(st_bad), 32'd0);

    // unsorted table, then a result held against back-pressure
    load_table('{12'd100, 12'd90, 12'd300}, 1);
    chk("unsorted_sort_err", 32'(sort_err_out), 32'd1);
    chk("unsorted_len", 32'(tbl_len_out), 32'd3);
    issue_req(12'd300, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      chk("hold_res_val", 32'(res_val_out), 32'd300);
      chk("hold_res_valid", 32'(res_valid_out), 32'd1);
      chk("hold_req_ready", 32'(req_ready_out), 32'd0);
    end
    res_ready_in = 1'b1;
    @(negedge clk_in);
    res_ready_in = 1'b0;

    // fill to capacity without a last marker
    tq = {};
    for (int i = 0; i < BRAM_SIZE; i++) tq.push_back(12'(i * 16 + 1));
    load_table(tq, 0);
    chk("full_len", 32'(tbl_len_out), 32'(BRAM_SIZE));
    chk("full_sort_err", 32'(sort_err_out), 32'd1);
    check_req(12'd4000);

    // reset in the middle of a search
    load_table('{12'd100, 12'd200, 12'd300, 12'd400}, 1);
    req_val_in = 12'd450;
    req_valid_in = 1'b1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    t = 0;
    while (!srch_searching_out && t < 20) begin
      @(negedge clk_in);
      t++;
    end
    chk("midsearch_searching", 32'(srch_searching_out), 32'd1);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check_reset_outputs("midreset");
    rst_in = 1'b1;
    n = 0;
    t = 0;
    while (srch_rst_out && t < 20) begin
      n++;
      @(negedge clk_in);
      t++;
    end
    chk("midreset_srch_rst_cycles", 32'(n), 32'd2);
    chk("midreset_tbl_len", 32'(tbl_len_out), 32'd0);
    chk("midreset_busy", 32'(busy_out), 32'd0);

    chk("searching_while_found", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
